// File: rtl/dup_mask_ctrl.sv
// -----------------------------------------------------------------------------
// dup_mask_ctrl
//
// Produces the per-beat lane-duplication mask for the datapath. Each accepted
// keep vector yields one registered mask one cycle later on a valid-only port.
// The mask FIFO downstream cannot push back, so the block tracks outstanding
// masks and never exceeds MAX_IN_TRANSIT of them. Policy changes wait until
// every outstanding mask has been consumed, then take effect atomically.
//
// Optional build macro: DUP_MASK_STATS_EN adds saturating statistics counters
// (dup_lane_count, mask_count). The default build has neither port nor logic.
//
// Ports:
//   clk            clock
//   rst_n          synchronous active-low reset
//   cfg_valid      policy update request (held until cfg_ready)
//   cfg_mode       0=PASS 1=FILL_LEFT 2=BROADCAST 3=reserved (acts as PASS)
//   cfg_ready      one-cycle pulse when the new policy is applied
//   keep_valid     keep vector offered for the next data beat
//   keep_data      per-lane keep bits
//   keep_ready     keep vector accepted this cycle
//   mask_valid     one-cycle pulse, writes mask_data into the datapath FIFO
//   mask_data      lane i at [i*(1+OW) +: 1+OW], MSB duplicate, low OW origin
//   beat_done      datapath consumed one beat and its mask
//   outstanding    masks issued but not yet consumed
//   busy           not in RUN, or masks still outstanding
//   dup_lane_count (stats build) total duplicate lanes issued, saturating
//   mask_count     (stats build) total masks issued, saturating
//   err_underflow  sticky: beat_done seen with nothing outstanding
// -----------------------------------------------------------------------------
module dup_mask_ctrl #(
    parameter int NUM_ELEMENTS   = 8,
    parameter int MAX_IN_TRANSIT = 16,
    localparam int OW = $clog2(NUM_ELEMENTS),
    localparam int CW = $clog2(MAX_IN_TRANSIT + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_valid,
    input  logic [1:0]                     cfg_mode,
    output logic                           cfg_ready,
    input  logic                           keep_valid,
    input  logic [NUM_ELEMENTS-1:0]        keep_data,
    output logic                           keep_ready,
    output logic                           mask_valid,
    output logic [NUM_ELEMENTS*(1+OW)-1:0] mask_data,
    input  logic                           beat_done,
    output logic [CW-1:0]                  outstanding,
    output logic                           busy,
`ifdef DUP_MASK_STATS_EN
    output logic [31:0]                    dup_lane_count,
    output logic [31:0]                    mask_count,
`endif
    output logic                           err_underflow
);

    localparam int EW = 1 + OW;

    localparam logic [1:0] MODE_PASS      = 2'd0;
    localparam logic [1:0] MODE_FILL_LEFT = 2'd1;
    localparam logic [1:0] MODE_BROADCAST = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    state_t                        state_reg, state_next;
    logic [1:0]                    mode_reg;
    logic [1:0]                    pending_reg;
    logic [CW-1:0]                 outstanding_reg, outstanding_next;
    logic                          mask_valid_reg;
    logic [NUM_ELEMENTS*EW-1:0]    mask_data_reg;
    logic [NUM_ELEMENTS*EW-1:0]    mask_next;
    logic                          err_underflow_reg;
    logic                          accept;
    logic                          credit_release;
    logic [OW-1:0]                 first_idx;
    logic                          keep_any;

    // ------------------------------------------------------------------
    // Credit handshake. A beat_done in the same cycle frees a slot, so a
    // full counter can still accept when the datapath drains one.
    // ------------------------------------------------------------------
    assign keep_ready = (state_reg == ST_RUN) && !cfg_valid &&
                        ((outstanding_reg < CW'(MAX_IN_TRANSIT)) || beat_done);
    assign accept         = keep_valid && keep_ready;
    assign credit_release = beat_done && (outstanding_reg != '0);

    always_comb begin
        outstanding_next = outstanding_reg;
        if (accept && !credit_release) begin
            outstanding_next = outstanding_reg + CW'(1);
        end else if (!accept && credit_release) begin
            outstanding_next = outstanding_reg - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Policy FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cfg_ready  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (cfg_valid) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (outstanding_next == '0) begin
                    state_next = ST_APPLY;
                end
            end
            ST_APPLY: begin
                cfg_ready  = 1'b1;
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Mask computation from the offered keep vector and current policy.
    // Only evaluated meaningfully on accept; mode cannot change while
    // accepts are possible because accepts only happen in RUN.
    // ------------------------------------------------------------------
    assign keep_any = |keep_data;

    // Lowest kept lane: scan downward so the last hit is the lowest index.
    always_comb begin
        first_idx = '0;
        for (int j = NUM_ELEMENTS - 1; j >= 0; j--) begin
            if (keep_data[j]) begin
                first_idx = OW'(j);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMENTS; gi++) begin : g_lane
            logic          lo_found;
            logic [OW-1:0] lo_idx;
            logic [OW-1:0] hi_idx;
            logic          lane_dup;
            logic [OW-1:0] lane_org;

            // Nearest kept lane below (ascending scan, last hit is highest)
            // and nearest kept lane above (descending scan, last hit lowest).
            always_comb begin
                lo_found = 1'b0;
                lo_idx   = '0;
                for (int j = 0; j < gi; j++) begin
                    if (keep_data[j]) begin
                        lo_found = 1'b1;
                        lo_idx   = OW'(j);
                    end
                end
                hi_idx = '0;
                for (int j = NUM_ELEMENTS - 1; j > gi; j--) begin
                    if (keep_data[j]) begin
                        hi_idx = OW'(j);
                    end
                end
            end

            // An all-zero keep has no source lane, so every entry stays zero.
            always_comb begin
                lane_dup = 1'b0;
                lane_org = '0;
                if (keep_any && !keep_data[gi]) begin
                    case (mode_reg)
                        MODE_FILL_LEFT: begin
                            lane_dup = 1'b1;
                            lane_org = lo_found ? lo_idx : hi_idx;
                        end
                        MODE_BROADCAST: begin
                            lane_dup = 1'b1;
                            lane_org = first_idx;
                        end
                        default: begin
                            lane_dup = 1'b0;
                            lane_org = '0;
                        end
                    endcase
                end
            end

            assign mask_next[gi*EW +: EW] = {lane_dup, lane_org};
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg         <= ST_RUN;
            mode_reg          <= MODE_PASS;
            pending_reg       <= MODE_PASS;
            outstanding_reg   <= '0;
            mask_valid_reg    <= 1'b0;
            mask_data_reg     <= '0;
            err_underflow_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            outstanding_reg <= outstanding_next;
            mask_valid_reg  <= accept;
            if (accept) begin
                mask_data_reg <= mask_next;
            end
            if (state_reg == ST_RUN && cfg_valid) begin
                pending_reg <= cfg_mode;
            end
            if (state_reg == ST_APPLY) begin
                mode_reg <= pending_reg;
            end
            if (beat_done && outstanding_reg == '0) begin
                err_underflow_reg <= 1'b1;
            end
        end
    end

    assign mask_valid    = mask_valid_reg;
    assign mask_data     = mask_data_reg;
    assign outstanding   = outstanding_reg;
    assign err_underflow = err_underflow_reg;
    assign busy          = (state_reg != ST_RUN) || (outstanding_reg != '0);

`ifdef DUP_MASK_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics, counted from the registered mask output.
    // ------------------------------------------------------------------
    logic [31:0] dup_lane_count_reg;
    logic [31:0] mask_count_reg;
    logic [32:0] dup_sum;

    always_comb begin
        dup_sum = {1'b0, dup_lane_count_reg};
        for (int i = 0; i < NUM_ELEMENTS; i++) begin
            dup_sum = dup_sum + 33'(mask_data_reg[i*EW + EW - 1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dup_lane_count_reg <= '0;
            mask_count_reg     <= '0;
        end else if (mask_valid_reg) begin
            dup_lane_count_reg <= dup_sum[32] ? 32'hFFFF_FFFF : dup_sum[31:0];
            if (mask_count_reg != 32'hFFFF_FFFF) begin
                mask_count_reg <= mask_count_reg + 32'd1;
            end
        end
    end

    assign dup_lane_count = dup_lane_count_reg;
    assign mask_count     = mask_count_reg;
`endif

endmodule

// File: tb/tb_dup_mask_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dup_mask_ctrl
//
// Directed bench for dup_mask_ctrl with NUM_ELEMENTS=8, MAX_IN_TRANSIT=4.
// A vector table covers the mask policies; hand-written sequences cover the
// credit limit, policy drain, underflow and mid-operation reset. Inputs are
// driven and outputs sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_dup_mask_ctrl;

    localparam int NE  = 8;
    localparam int MIT = 4;
    localparam int OW  = 3;
    localparam int CW  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  cfg_valid;
    logic [1:0]            cfg_mode;
    logic                  cfg_ready;
    logic                  keep_valid;
    logic [NE-1:0]         keep_data;
    logic                  keep_ready;
    logic                  mask_valid;
    logic [NE*(1+OW)-1:0]  mask_data;
    logic                  beat_done;
    logic [CW-1:0]         outstanding;
    logic                  busy;
    logic                  err_underflow;
`ifdef DUP_MASK_STATS_EN
    logic [31:0]           dup_lane_count;
    logic [31:0]           mask_count;
`endif

    always #5 clk = ~clk;

    dup_mask_ctrl #(
        .NUM_ELEMENTS  (NE),
        .MAX_IN_TRANSIT(MIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_mode      (cfg_mode),
        .cfg_ready     (cfg_ready),
        .keep_valid    (keep_valid),
        .keep_data     (keep_data),
        .keep_ready    (keep_ready),
        .mask_valid    (mask_valid),
        .mask_data     (mask_data),
        .beat_done     (beat_done),
        .outstanding   (outstanding),
        .busy          (busy),
`ifdef DUP_MASK_STATS_EN
        .dup_lane_count(dup_lane_count),
        .mask_count    (mask_count),
`endif
        .err_underflow (err_underflow)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [7:0]  keep;
        logic [31:0] exp_mask;
    } vec_t;

    vec_t       vecs[12];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] cur_mode = 2'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic set_mode(input logic [1:0] m);
        int seen;
        seen      = -1;
        cfg_valid = 1'b1;
        cfg_mode  = m;
        #1;
        check("cfg_keep_ready_low", 64'(keep_ready), 64'd0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (cfg_ready) begin
                seen = c;
                break;
            end
        end
        cfg_valid = 1'b0;
        check("cfg_ready_latency", 64'(seen), 64'd1);
        @(negedge clk);
        check("cfg_ready_single", 64'(cfg_ready), 64'd0);
        cur_mode = m;
    endtask

    task automatic push(input logic [7:0] k, input logic [31:0] exp_mask,
                        input logic [CW-1:0] exp_out);
        keep_valid = 1'b1;
        keep_data  = k;
        #1;
        check("push_keep_ready", 64'(keep_ready), 64'd1);
        @(negedge clk);
        keep_valid = 1'b0;
        check("push_mask_valid", 64'(mask_valid), 64'd1);
        check("push_mask_data", 64'(mask_data), 64'(exp_mask));
        check("push_outstanding", 64'(outstanding), 64'(exp_out));
    endtask

    task automatic pulse_done();
        beat_done = 1'b1;
        @(negedge clk);
        beat_done = 1'b0;
    endtask

    initial begin
        int first_ready;
        int ready_cnt;
        int mv_cnt;

        // mask_data hex digit i (from the right) is lane i: {dup, origin[2:0]}
        vecs[0]  = '{2'd1, 8'b0001_0010, 32'hCCC0_9909};
        vecs[1]  = '{2'd1, 8'h80,        32'h0FFF_FFFF};
        vecs[2]  = '{2'd1, 8'h01,        32'h8888_8880};
        vecs[3]  = '{2'd1, 8'b0100_0100, 32'hE0AA_A0AA};
        vecs[4]  = '{2'd1, 8'hFF,        32'h0000_0000};
        vecs[5]  = '{2'd1, 8'h00,        32'h0000_0000};
        vecs[6]  = '{2'd2, 8'b1010_0000, 32'h0D0D_DDDD};
        vecs[7]  = '{2'd2, 8'h00,        32'h0000_0000};
        vecs[8]  = '{2'd2, 8'h81,        32'h0888_8880};
        vecs[9]  = '{2'd2, 8'h10,        32'hCCC0_CCCC};
        vecs[10] = '{2'd3, 8'h0F,        32'h0000_0000};
        vecs[11] = '{2'd0, 8'hA5,        32'h0000_0000};

        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_mode   = 2'd0;
        keep_valid = 1'b0;
        keep_data  = '0;
        beat_done  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_mask_valid", 64'(mask_valid), 64'd0);
        check("rst_mask_data", 64'(mask_data), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_err", 64'(err_underflow), 64'd0);
        check("rst_outstanding", 64'(outstanding), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_keep_ready", 64'(keep_ready), 64'd1);
        @(negedge clk);

        // Mask policy table
        for (int v = 0; v < 12; v++) begin
            if (vecs[v].mode != cur_mode) begin
                set_mode(vecs[v].mode);
            end
            push(vecs[v].keep, vecs[v].exp_mask, 3'd1);
            $display("vec %0d mode %0d keep %b mask %h", v, vecs[v].mode, vecs[v].keep, mask_data);
            pulse_done();
            check("vec_mask_valid_drop", 64'(mask_valid), 64'd0);
            check("vec_outstanding_zero", 64'(outstanding), 64'd0);
        end

        // Credit limit: fill to MAX_IN_TRANSIT, then accept with beat_done
        set_mode(2'd1);
        keep_valid = 1'b1;
        keep_data  = 8'b0001_0010;
        for (int i = 0; i < MIT; i++) begin
            #1;
            check("credit_fill_ready", 64'(keep_ready), 64'd1);
            @(negedge clk);
        end
        #1;
        check("credit_full_outstanding", 64'(outstanding), 64'd4);
        check("credit_full_ready", 64'(keep_ready), 64'd0);
        check("credit_full_busy", 64'(busy), 64'd1);
        beat_done = 1'b1;
        #1;
        check("credit_bd_ready", 64'(keep_ready), 64'd1);
        @(negedge clk);
        keep_valid = 1'b0;
        beat_done  = 1'b0;
        check("credit_swap_outstanding", 64'(outstanding), 64'd4);
        check("credit_swap_mask_valid", 64'(mask_valid), 64'd1);
        check("credit_swap_mask", 64'(mask_data), 64'hCCC0_9909);
        $display("credit swap outstanding %0d", outstanding);
        pulse_done();
        check("credit_outstanding_3", 64'(outstanding), 64'd3);

        // Policy change with 3 outstanding: drains before applying
        keep_valid = 1'b1;
        keep_data  = 8'h12;
        cfg_valid  = 1'b1;
        cfg_mode   = 2'd0;
        #1;
        check("drain_keep_ready_low", 64'(keep_ready), 64'd0);
        first_ready = -1;
        ready_cnt   = 0;
        mv_cnt      = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            keep_valid = 1'b0;
            if (mask_valid) mv_cnt++;
            if (cfg_ready) begin
                ready_cnt++;
                if (first_ready < 0) first_ready = c;
                cfg_valid = 1'b0;
            end
            if (c == 3) check("drain_busy", 64'(busy), 64'd1);
            beat_done = (c == 0 || c == 2 || c == 4);
        end
        beat_done = 1'b0;
        check("drain_ready_cycle", 64'(first_ready), 64'd5);
        check("drain_ready_count", 64'(ready_cnt), 64'd1);
        check("drain_no_mask", 64'(mv_cnt), 64'd0);
        check("drain_outstanding", 64'(outstanding), 64'd0);
        check("drain_busy_clear", 64'(busy), 64'd0);
        $display("policy change applied at drain cycle %0d", first_ready);
        cur_mode = 2'd0;
        push(8'h12, 32'h0000_0000, 3'd1);
        pulse_done();

        // Underflow, then reset mid-drain
        set_mode(2'd1);
        check("uf_err_before", 64'(err_underflow), 64'd0);
        pulse_done();
        check("uf_err_set", 64'(err_underflow), 64'd1);
        check("uf_outstanding", 64'(outstanding), 64'd0);
        @(negedge clk);
        check("uf_err_sticky", 64'(err_underflow), 64'd1);
        push(8'h01, 32'h8888_8880, 3'd1);
        push(8'h80, 32'h0FFF_FFFF, 3'd2);
        cfg_valid = 1'b1;
        cfg_mode  = 2'd2;
        @(negedge clk);
        check("mid_drain_busy", 64'(busy), 64'd1);
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_err", 64'(err_underflow), 64'd0);
        check("mid_rst_outstanding", 64'(outstanding), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_mask_valid", 64'(mask_valid), 64'd0);
        check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd0);
        $display("reset mid-drain: err %0d outstanding %0d", err_underflow, outstanding);
        @(negedge clk);
        cur_mode = 2'd0;
        push(8'h01, 32'h0000_0000, 3'd1);
        pulse_done();

`ifdef DUP_MASK_STATS_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("stats_rst_dup", 64'(dup_lane_count), 64'd0);
        check("stats_rst_masks", 64'(mask_count), 64'd0);
        @(negedge clk);
        cur_mode = 2'd0;
        set_mode(2'd1);
        push(8'h01, 32'h8888_8880, 3'd1);
        push(8'hFF, 32'h0000_0000, 3'd2);
        @(negedge clk);
        check("stats_dup_lanes", 64'(dup_lane_count), 64'd7);
        check("stats_masks", 64'(mask_count), 64'd2);
        $display("stats dup_lane_count %0d mask_count %0d", dup_lane_count, mask_count);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
